// File: rtl/pci_master_seq.sv
// PCI bus master sequencer: request, address, burst data and turnaround.
// Define PCI_LATENCY_TIMER_EN to enable the latency-timer preempt.
module pci_master_seq #(
    parameter int unsigned LAT_CYCLES     = 32,
    parameter int unsigned DEVSEL_TIMEOUT = 5
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       start,
    input  logic [7:0] len,
    input  logic       gnt_l,
    input  logic       frame_l_in,
    input  logic       irdy_l_in,
    input  logic       trdy_l,
    input  logic       devsel_l,
    input  logic       stop_l,
    output logic       req_l,
    output logic       frame_l,
    output logic       irdy_l,
    output logic       frame_oe,
    output logic       irdy_oe,
    output logic       ad_oe,
    output logic       addr_phase,
    output logic       data_xfer,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic [8:0] rem
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_TURN = 3'd4;

    localparam logic [7:0] DEV_LAST = 8'(DEVSEL_TIMEOUT - 1);

    logic [2:0] state;
    logic       ending;
    logic       preempted;
    logic       dev_seen;
    logic [7:0] dev_cnt;
    logic       xfer;
    logic       tmo;
    logic       pre;
    logic [8:0] rem_nx;

    // a target abort never counts the phase even if trdy is asserted
    assign xfer = (state == S_DATA) && !ending && !irdy_l && !trdy_l
                  && !(!stop_l && devsel_l);
    assign data_xfer  = xfer;
    assign addr_phase = (state == S_ADDR);
    assign rem_nx     = xfer ? rem - 9'd1 : rem;
    assign tmo        = (state == S_DATA) && !dev_seen && devsel_l
                        && (dev_cnt == DEV_LAST);

`ifdef PCI_LATENCY_TIMER_EN
    logic [15:0] lat_cnt;

    assign pre = (lat_cnt == 16'd0) && gnt_l && (rem_nx > 9'd1)
                 && !frame_l && !preempted;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            lat_cnt <= '0;
        end else if (state == S_ADDR) begin
            lat_cnt <= 16'(LAT_CYCLES);
        end else if (state == S_DATA && lat_cnt != 16'd0) begin
            lat_cnt <= lat_cnt - 16'd1;
        end
    end
`else
    assign pre = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= S_IDLE;
            req_l     <= 1'b1;
            frame_l   <= 1'b1;
            irdy_l    <= 1'b1;
            frame_oe  <= 1'b0;
            irdy_oe   <= 1'b0;
            ad_oe     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= 2'b00;
            rem       <= '0;
            ending    <= 1'b0;
            preempted <= 1'b0;
            dev_seen  <= 1'b0;
            dev_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem    <= (len == 8'd0) ? 9'd256 : {1'b0, len};
                        busy   <= 1'b1;
                        req_l  <= 1'b0;
                        status <= 2'b00;
                        state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!gnt_l && frame_l_in && irdy_l_in) begin
                        state     <= S_ADDR;
                        frame_l   <= 1'b0;
                        irdy_l    <= 1'b1;
                        frame_oe  <= 1'b1;
                        irdy_oe   <= 1'b1;
                        ad_oe     <= 1'b1;
                        ending    <= 1'b0;
                        preempted <= 1'b0;
                        dev_seen  <= 1'b0;
                        dev_cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    state  <= S_DATA;
                    irdy_l <= 1'b0;
                    if (rem == 9'd1) begin
                        frame_l <= 1'b1;
                        req_l   <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!devsel_l) begin
                        dev_seen <= 1'b1;
                    end else if (!dev_seen) begin
                        dev_cnt <= dev_cnt + 8'd1;
                    end
                    // final phase on the bus: frame already released
                    if (ending || (xfer && frame_l) || (!stop_l && frame_l)) begin
                        if (!ending) begin
                            rem <= rem_nx;
                            if (xfer && frame_l) begin
                                status <= preempted ? 2'b11 : 2'b00;
                            end else begin
                                status <= devsel_l ? 2'b10 : 2'b11;
                            end
                        end
                        state   <= S_TURN;
                        frame_l <= 1'b1;
                        irdy_l  <= 1'b1;
                        ad_oe   <= 1'b0;
                        req_l   <= 1'b1;
                        ending  <= 1'b0;
                    end else if (!stop_l) begin
                        rem     <= rem_nx;
                        status  <= devsel_l ? 2'b10 : 2'b11;
                        frame_l <= 1'b1;
                        req_l   <= 1'b1;
                        ending  <= 1'b1;
                    end else begin
                        rem <= rem_nx;
                        if (tmo) begin
                            frame_l <= 1'b1;
                            req_l   <= 1'b1;
                            ending  <= 1'b1;
                            status  <= 2'b01;
                        end else if ((xfer && rem == 9'd2) || pre) begin
                            frame_l   <= 1'b1;
                            req_l     <= 1'b1;
                            preempted <= pre;
                        end
                    end
                end
                S_TURN: begin
                    state    <= S_IDLE;
                    frame_oe <= 1'b0;
                    irdy_oe  <= 1'b0;
                    ad_oe    <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
